// File: rtl/rv_writeback.sv
// ---------------------------------------------------------------------------
// rv_writeback
// Final pipeline stage. Takes the registered execute-stage writeback signals
// and the data-memory completion strobes, aligns and sign-extends load data,
// and drives the registered register-file write port. While a load or store
// is outstanding it requests a pipeline stall. A bounded wait counter aborts
// a hung access with a one-cycle bus-error pulse.
//
// Parameters
//   g_timeout_cycles : WAIT cycles tolerated before an access is aborted
//                      (1..65535)
// Ports
//   clk_i, rst_i       : clock, synchronous active-high reset
//   x_fun_i            : funct3 of the instruction (load width / sign)
//   x_load_i/x_store_i : single-cycle load / store request from execute
//   x_rd_i             : destination register
//   x_rd_value_i       : ALU / jump result for non-load writes
//   x_rd_write_i       : non-load register write request
//   x_dm_addr_i        : data address of the load / store
//   dm_data_l_i        : load data word, valid with dm_load_done_i
//   dm_load_done_i     : load completes this cycle
//   dm_store_done_i    : store completes this cycle
//   w_stall_req_o      : combinational pipeline stall request
//   w_bus_error_o      : registered one-cycle pulse on access timeout
//   rf_rd_o, rf_rd_value_o, rf_rd_write_o : registered register-file write
// ---------------------------------------------------------------------------
module rv_writeback #(
   parameter int unsigned g_timeout_cycles = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  x_fun_i,
   input  logic        x_load_i,
   input  logic        x_store_i,
   input  logic [4:0]  x_rd_i,
   input  logic [31:0] x_rd_value_i,
   input  logic        x_rd_write_i,
   input  logic [31:0] x_dm_addr_i,
   input  logic [31:0] dm_data_l_i,
   input  logic        dm_load_done_i,
   input  logic        dm_store_done_i,
   output logic        w_stall_req_o,
   output logic        w_bus_error_o,
   output logic [4:0]  rf_rd_o,
   output logic [31:0] rf_rd_value_o,
   output logic        rf_rd_write_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_LOAD,
      ST_WAIT_STORE
   } state_t;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(g_timeout_cycles);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  ld_fun_q, ld_fun_d;
   logic [4:0]  ld_rd_q, ld_rd_d;
   logic [1:0]  ld_off_q, ld_off_d;
   logic [4:0]  rf_rd_q, rf_rd_d;
   logic [31:0] rf_rd_value_q, rf_rd_value_d;
   logic        rf_rd_write_q, rf_rd_write_d;
   logic        bus_error_q, bus_error_d;
   logic        stall;

   // Select the addressed byte/halfword and extend it according to funct3.
   function automatic logic [31:0] align_load(input logic [2:0]  fun,
                                              input logic [1:0]  off,
                                              input logic [31:0] data);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      shifted = data >> {off, 3'b000};
      b       = shifted[7:0];
      h       = off[1] ? data[31:16] : data[15:0];
      case (fun)
         3'b000:  r = {{24{b[7]}}, b};
         3'b100:  r = {24'h000000, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b101:  r = {16'h0000, h};
         default: r = data;
      endcase
      return r;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      ld_fun_d      = ld_fun_q;
      ld_rd_d       = ld_rd_q;
      ld_off_d      = ld_off_q;
      rf_rd_d       = rf_rd_q;
      rf_rd_value_d = rf_rd_value_q;
      rf_rd_write_d = 1'b0;
      bus_error_d   = 1'b0;
      stall         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (x_load_i) begin
               if (dm_load_done_i) begin
                  rf_rd_d       = x_rd_i;
                  rf_rd_value_d = align_load(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
                  rf_rd_write_d = (x_rd_i != 5'd0);
               end else begin
                  ld_fun_d = x_fun_i;
                  ld_rd_d  = x_rd_i;
                  ld_off_d = x_dm_addr_i[1:0];
                  cnt_d    = 16'd0;
                  state_d  = ST_WAIT_LOAD;
                  stall    = 1'b1;
               end
            end else begin
               if (x_rd_write_i) begin
                  rf_rd_d       = x_rd_i;
                  rf_rd_value_d = x_rd_value_i;
                  rf_rd_write_d = (x_rd_i != 5'd0);
               end
               if (x_store_i && !dm_store_done_i) begin
                  cnt_d   = 16'd0;
                  state_d = ST_WAIT_STORE;
                  stall   = 1'b1;
               end
            end
         end

         ST_WAIT_LOAD: begin
            // Done takes priority over a timeout in the limit cycle.
            if (dm_load_done_i) begin
               rf_rd_d       = ld_rd_q;
               rf_rd_value_d = align_load(ld_fun_q, ld_off_q, dm_data_l_i);
               rf_rd_write_d = (ld_rd_q != 5'd0);
               state_d       = ST_IDLE;
            end else if (cnt_q == TIMEOUT_LIMIT) begin
               bus_error_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
               stall = 1'b1;
            end
         end

         ST_WAIT_STORE: begin
            if (dm_store_done_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == TIMEOUT_LIMIT) begin
               bus_error_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
               stall = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst_i) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 16'd0;
         ld_fun_q      <= 3'd0;
         ld_rd_q       <= 5'd0;
         ld_off_q      <= 2'd0;
         rf_rd_q       <= 5'd0;
         rf_rd_value_q <= 32'd0;
         rf_rd_write_q <= 1'b0;
         bus_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ld_fun_q      <= ld_fun_d;
         ld_rd_q       <= ld_rd_d;
         ld_off_q      <= ld_off_d;
         rf_rd_q       <= rf_rd_d;
         rf_rd_value_q <= rf_rd_value_d;
         rf_rd_write_q <= rf_rd_write_d;
         bus_error_q   <= bus_error_d;
      end
   end

   // The stall is combinational, so it is gated directly by reset.
   assign w_stall_req_o = stall & ~rst_i;
   assign w_bus_error_o = bus_error_q;
   assign rf_rd_o       = rf_rd_q;
   assign rf_rd_value_o = rf_rd_value_q;
   assign rf_rd_write_o = rf_rd_write_q;

endmodule

// File: tb/tb_rv_writeback.sv
// ---------------------------------------------------------------------------
// tb_rv_writeback
// Directed self-checking bench for rv_writeback with g_timeout_cycles = 4.
// Inputs change 1 time unit after the rising edge. Registered outputs are
// checked at that point, and the combinational stall is checked one time unit
// later, once the new inputs have settled.
// ---------------------------------------------------------------------------
module tb_rv_writeback;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [2:0]  x_fun_i;
   logic        x_load_i;
   logic        x_store_i;
   logic [4:0]  x_rd_i;
   logic [31:0] x_rd_value_i;
   logic        x_rd_write_i;
   logic [31:0] x_dm_addr_i;
   logic [31:0] dm_data_l_i;
   logic        dm_load_done_i;
   logic        dm_store_done_i;
   logic        w_stall_req_o;
   logic        w_bus_error_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_rd_value_o;
   logic        rf_rd_write_o;

   int n_checks = 0;
   int n_errors = 0;

   rv_writeback #(.g_timeout_cycles(4)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .x_fun_i         (x_fun_i),
      .x_load_i        (x_load_i),
      .x_store_i       (x_store_i),
      .x_rd_i          (x_rd_i),
      .x_rd_value_i    (x_rd_value_i),
      .x_rd_write_i    (x_rd_write_i),
      .x_dm_addr_i     (x_dm_addr_i),
      .dm_data_l_i     (dm_data_l_i),
      .dm_load_done_i  (dm_load_done_i),
      .dm_store_done_i (dm_store_done_i),
      .w_stall_req_o   (w_stall_req_o),
      .w_bus_error_o   (w_bus_error_o),
      .rf_rd_o         (rf_rd_o),
      .rf_rd_value_o   (rf_rd_value_o),
      .rf_rd_write_o   (rf_rd_write_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_x();
      x_fun_i         = 3'd0;
      x_load_i        = 1'b0;
      x_store_i       = 1'b0;
      x_rd_i          = 5'd0;
      x_rd_value_i    = 32'd0;
      x_rd_write_i    = 1'b0;
      x_dm_addr_i     = 32'd0;
      dm_load_done_i  = 1'b0;
      dm_store_done_i = 1'b0;
   endtask

   task automatic check_stall(input string tag, input logic exp);
      settle();
      check({tag, " stall"}, 32'(w_stall_req_o), 32'(exp));
   endtask

   // Zero-wait load: request and done in the same cycle, write one cycle later.
   task automatic load_now(input string tag, input logic [2:0] fun, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] data,
                           input logic exp_wr, input logic [31:0] exp_val);
      x_load_i       = 1'b1;
      x_fun_i        = fun;
      x_dm_addr_i    = addr;
      x_rd_i         = rd;
      dm_data_l_i    = data;
      dm_load_done_i = 1'b1;
      check_stall(tag, 1'b0);
      next_cycle();
      clear_x();
      check({tag, " wr"}, 32'(rf_rd_write_o), 32'(exp_wr));
      if (exp_wr) begin
         check({tag, " rd"}, 32'(rf_rd_o), 32'(rd));
         check({tag, " val"}, rf_rd_value_o, exp_val);
      end
   endtask

   typedef struct {
      logic [2:0]  fun;
      logic [31:0] addr;
      logic [31:0] exp;
   } lvec_t;

   initial begin
      lvec_t lv[5];
      lv[0] = '{3'b000, 32'h1000_0003, 32'hFFFF_FF80}; // LB
      lv[1] = '{3'b100, 32'h1000_0003, 32'h0000_0080}; // LBU
      lv[2] = '{3'b001, 32'h1000_0002, 32'hFFFF_80FF}; // LH
      lv[3] = '{3'b101, 32'h1000_0000, 32'h0000_7F01}; // LHU
      lv[4] = '{3'b010, 32'h1000_0000, 32'h80FF_7F01}; // LW

      clear_x();
      dm_data_l_i = 32'd0;
      rst_i       = 1'b1;
      next_cycle();
      next_cycle();
      // Reset state; a load request while in reset must not raise the stall.
      check("rst wr",  32'(rf_rd_write_o), 32'd0);
      check("rst rd",  32'(rf_rd_o), 32'd0);
      check("rst val", rf_rd_value_o, 32'd0);
      check("rst err", 32'(w_bus_error_o), 32'd0);
      x_load_i = 1'b1;
      check_stall("rst", 1'b0);
      clear_x();
      next_cycle();
      rst_i = 1'b0;

      // ALU write
      x_rd_write_i = 1'b1;
      x_rd_i       = 5'd5;
      x_rd_value_i = 32'hDEAD_BEEF;
      check_stall("alu", 1'b0);
      next_cycle();
      clear_x();
      check("alu wr",  32'(rf_rd_write_o), 32'd1);
      check("alu rd",  32'(rf_rd_o), 32'd5);
      check("alu val", rf_rd_value_o, 32'hDEAD_BEEF);
      next_cycle();
      check("alu wr low", 32'(rf_rd_write_o), 32'd0);

      // Zero-wait loads
      foreach (lv[i]) begin
         load_now($sformatf("ld%0d", i), lv[i].fun, lv[i].addr, 5'd10, 32'h80FF_7F01, 1'b1, lv[i].exp);
      end
      load_now("ld x0", 3'b010, 32'h1000_0000, 5'd0, 32'h1234_5678, 1'b0, 32'd0);

      // Delayed LBU at offset 1 to rd 7, done three cycles later, then an
      // ALU write issued right after the return to IDLE.
      x_load_i    = 1'b1;
      x_fun_i     = 3'b100;
      x_rd_i      = 5'd7;
      x_dm_addr_i = 32'h2000_0001;
      check_stall("dl c0", 1'b1);
      next_cycle();
      clear_x();
      x_rd_i  = 5'd9;            // execute lines change; must be ignored
      x_fun_i = 3'b010;
      check("dl c1 wr", 32'(rf_rd_write_o), 32'd0);
      check_stall("dl c1", 1'b1);
      next_cycle();
      check_stall("dl c2", 1'b1);
      next_cycle();
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'h80FF_7F01;
      check_stall("dl c3", 1'b0);
      next_cycle();
      clear_x();
      x_rd_write_i = 1'b1;
      x_rd_i       = 5'd8;
      x_rd_value_i = 32'h0000_0042;
      check("dl c4 wr",  32'(rf_rd_write_o), 32'd1);
      check("dl c4 rd",  32'(rf_rd_o), 32'd7);
      check("dl c4 val", rf_rd_value_o, 32'h0000_007F);
      next_cycle();
      clear_x();
      check("b2b wr",  32'(rf_rd_write_o), 32'd1);
      check("b2b rd",  32'(rf_rd_o), 32'd8);
      check("b2b val", rf_rd_value_o, 32'h0000_0042);

      // Store with done two cycles later
      x_store_i = 1'b1;
      check_stall("st c0", 1'b1);
      next_cycle();
      clear_x();
      check_stall("st c1", 1'b1);
      next_cycle();
      dm_store_done_i = 1'b1;
      check_stall("st c2", 1'b0);
      next_cycle();
      clear_x();
      check("st wr", 32'(rf_rd_write_o), 32'd0);
      check("st err", 32'(w_bus_error_o), 32'd0);

      // Timeout: WAIT cycles with count 0..3 stall, the fifth aborts.
      x_load_i = 1'b1;
      x_rd_i   = 5'd3;
      check_stall("to c0", 1'b1);
      next_cycle();
      clear_x();
      for (int c = 1; c <= 4; c++) begin
         check_stall($sformatf("to c%0d", c), 1'b1);
         check($sformatf("to c%0d err", c), 32'(w_bus_error_o), 32'd0);
         next_cycle();
      end
      check_stall("to c5", 1'b0);
      next_cycle();
      x_rd_write_i = 1'b1;          // accepted only if back in IDLE
      x_rd_i       = 5'd4;
      x_rd_value_i = 32'h0000_1234;
      check("to c6 err", 32'(w_bus_error_o), 32'd1);
      check("to c6 wr",  32'(rf_rd_write_o), 32'd0);
      next_cycle();
      clear_x();
      check("to c7 err", 32'(w_bus_error_o), 32'd0);
      check("to c7 wr",  32'(rf_rd_write_o), 32'd1);
      check("to c7 rd",  32'(rf_rd_o), 32'd4);

      // Done in the limit cycle wins over the timeout.
      x_load_i    = 1'b1;
      x_fun_i     = 3'b010;
      x_rd_i      = 5'd6;
      x_dm_addr_i = 32'h3000_0000;
      next_cycle();
      clear_x();
      for (int c = 1; c <= 4; c++) next_cycle();
      dm_load_done_i = 1'b1;
      dm_data_l_i    = 32'hCAFE_F00D;
      check_stall("lim c5", 1'b0);
      next_cycle();
      clear_x();
      check("lim err", 32'(w_bus_error_o), 32'd0);
      check("lim wr",  32'(rf_rd_write_o), 32'd1);
      check("lim rd",  32'(rf_rd_o), 32'd6);
      check("lim val", rf_rd_value_o, 32'hCAFE_F00D);

      // Reset in the middle of WAIT_LOAD
      x_load_i = 1'b1;
      x_rd_i   = 5'd11;
      next_cycle();
      clear_x();
      rst_i = 1'b1;
      check_stall("rw rst", 1'b0);
      next_cycle();
      rst_i          = 1'b0;
      dm_load_done_i = 1'b1;         // would complete the load if still waiting
      dm_data_l_i    = 32'h5555_AAAA;
      check("rw wr",  32'(rf_rd_write_o), 32'd0);
      check("rw err", 32'(w_bus_error_o), 32'd0);
      check("rw rd",  32'(rf_rd_o), 32'd0);
      check("rw val", rf_rd_value_o, 32'd0);
      check_stall("rw idle", 1'b0);
      next_cycle();
      clear_x();
      check("rw stray wr", 32'(rf_rd_write_o), 32'd0);

      // Stray done strobes in IDLE
      dm_load_done_i  = 1'b1;
      dm_store_done_i = 1'b1;
      dm_data_l_i     = 32'hFFFF_FFFF;
      check_stall("stray", 1'b0);
      next_cycle();
      clear_x();
      check("stray wr",  32'(rf_rd_write_o), 32'd0);
      check("stray err", 32'(w_bus_error_o), 32'd0);
      check_stall("stray after", 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
